fmap_ii_reader: RTL and testbench

Read-side sequencer for the layer-II feature-map store (144 banks × DEPTH words, one-cycle synchronous read). On a start pulse it sweeps every word of every bank and serializes them into a valid/ready stream for the downstream fully-connected stage, one word per cycle. The block handles the one-cycle SRAM read latency and downstream backpressure internally. The write side must be quiescent while `busy` is high; this is guaranteed by the controller, not checked here.

---
 rtl/fmap_ii_reader.sv | 193 +++++++++++++++++++
 tb/tb_fmap_ii_reader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmap_ii_reader.sv
// Sweeps all banks of the layer-II feature-map store into a valid/ready stream, address-major.
// Start to first word is 2 cycles; a 2-entry credit-guarded output FIFO absorbs backpressure.

module fmap_ii_fifo #(
  parameter int W = 8,
  parameter int N = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic                     head_vld,
  output logic [W-1:0]             head_dat,
  output logic [$clog2(N+1)-1:0]   count
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0]  mem [N];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(N-1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_vld = (count != '0);
  assign head_dat = mem[rd_ptr];
endmodule

module fmap_ii_reader #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int BANKS      = 144,
  parameter int IDX_WIDTH  = $clog2(BANKS*DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] fmap_rd_addr [BANKS-1:0],
  input  logic [DATA_WIDTH-1:0] fmap_rd_data [BANKS-1:0],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [IDX_WIDTH-1:0]  out_index,
  output logic                  out_last
);
  localparam int BW = $clog2(BANKS);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] dat;
    logic [IDX_WIDTH-1:0]  idx;
    logic                  last;
  } word_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] a_cnt;
  logic [BW-1:0]         b_cnt;
  logic [IDX_WIDTH-1:0]  k_cnt;
  logic [ADDR_WIDTH-1:0] rd_addr_q;

  logic                  s1_vld;
  logic [BW-1:0]         s1_bank;
  logic [IDX_WIDTH-1:0]  s1_idx;
  logic                  s1_last;

  logic                  clr, issue, done_nxt, at_end, pop, credit;
  logic [1:0]            fifo_cnt;
  logic [2:0]            occ_after;
  word_t                 push_word, head_word;

  assign at_end = (a_cnt == ADDR_WIDTH'(DEPTH-1)) && (b_cnt == BW'(BANKS-1));
  assign pop    = out_valid & out_ready;

  // A pop this cycle frees a slot, which is what lets the pipe run at one word per cycle.
  assign occ_after = {1'b0, fifo_cnt} + {2'b00, s1_vld} - {2'b00, pop};
  assign credit    = (occ_after < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    issue     = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ISSUE;
          clr       = 1'b1;
        end
      end
      ISSUE: begin
        if (credit) begin
          issue = 1'b1;
          if (at_end) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && out_last) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_cnt     <= '0;
      b_cnt     <= '0;
      k_cnt     <= '0;
      rd_addr_q <= '0;
      s1_vld    <= 1'b0;
      s1_bank   <= '0;
      s1_idx    <= '0;
      s1_last   <= 1'b0;
      done      <= 1'b0;
    end else begin
      s1_vld <= issue;
      done   <= done_nxt;
      if (clr) begin
        a_cnt <= '0;
        b_cnt <= '0;
        k_cnt <= '0;
      end else if (issue) begin
        rd_addr_q <= a_cnt;
        s1_bank   <= b_cnt;
        s1_idx    <= k_cnt;
        s1_last   <= at_end;
        k_cnt     <= k_cnt + 1'b1;
        if (b_cnt == BW'(BANKS-1)) begin
          b_cnt <= '0;
          a_cnt <= a_cnt + 1'b1;
        end else begin
          b_cnt <= b_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < BANKS; i++) fmap_rd_addr[i] = rd_addr_q;
  end

  assign push_word = '{dat: fmap_rd_data[s1_bank], idx: s1_idx, last: s1_last};

  fmap_ii_fifo #(.W($bits(word_t)), .N(2)) u_out_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (s1_vld),
    .push_dat (push_word),
    .pop      (pop),
    .head_vld (out_valid),
    .head_dat (head_word),
    .count    (fifo_cnt)
  );

  assign out_data  = head_word.dat;
  assign out_index = head_word.idx;
  assign out_last  = head_word.last;
  assign busy      = (state != IDLE);
endmodule

// File: tb/tb_fmap_ii_reader.sv
// Randomized bench for fmap_ii_reader against an index-arithmetic model of the sweep order.
module tb_fmap_ii_reader;
  localparam int AW = 3, DW = 16, DEPTH = 8, BANKS = 144, IW = 11;
  localparam int NW = BANKS * DEPTH;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic          busy, done, out_valid, out_last;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_index;
  logic [AW-1:0] fmap_rd_addr [BANKS-1:0];
  logic [DW-1:0] fmap_rd_data [BANKS-1:0];
  logic [DW-1:0] mem [BANKS-1:0][DEPTH-1:0];

  int total = 0, bad = 0;
  int cyc = 0;
  int exp_k = 0, words = 0, dones = 0, last_hs = 0;
  int rdy_mode = 0;
  int n_bad_addr, v_cnt, d_save;

  fmap_ii_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .BANKS(BANKS), .IDX_WIDTH(IW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .fmap_rd_addr (fmap_rd_addr),
    .fmap_rd_data (fmap_rd_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_index    (out_index),
    .out_last     (out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Store model: the reader's registered address is the array's read register.
  always_comb begin
    for (int b = 0; b < BANKS; b++) fmap_rd_data[b] = mem[b][fmap_rd_addr[b]];
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h) t=%0t", tag, got, got, exp, exp, $time);
    end
  endtask

  function automatic int model_dat(input int k);
    return int'(mem[k % BANKS][k / BANKS]);
  endfunction

  task automatic load(input bit pattern);
    for (int b = 0; b < BANKS; b++)
      for (int a = 0; a < DEPTH; a++)
        mem[b][a] = pattern ? DW'((a << 8) | (b & 8'hff)) : DW'($urandom);
  endtask

  task automatic clear_counts();
    exp_k = 0; words = 0; dones = 0; last_hs = 0;
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Stream monitor: every valid word must be the next word of the address-major sweep.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (out_valid) begin
          check("index", int'(out_index), exp_k);
          check("data", int'(out_data), model_dat(exp_k));
          check("last", int'(out_last), int'(exp_k == NW - 1));
          if (out_ready) begin
            words++;
            if (exp_k == NW - 1) begin
              last_hs = cyc;
              exp_k = 0;
            end else begin
              exp_k++;
            end
          end
        end
        if (done) begin
          dones++;
          check("done_lat", cyc - last_hs, 1);
          check("done_busy", int'(busy), 0);
        end
      end
    end
  end

  // Caller is one step after a rising edge; returns the same way.
  task automatic start_sweep();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_t0", int'(busy), 1);
    @(negedge clk) check("vld_t0", int'(out_valid), 0);
    @(negedge clk) check("vld_t1", int'(out_valid), 0);
    @(negedge clk) check("vld_t2", int'(out_valid), 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_seen", int'(done), 1);
  endtask

  task automatic wait_k(input int target, input int budget);
    int n = 0;
    while (exp_k < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("k_reached", int'(exp_k >= target), 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic idle_count(input int n, output int vld);
    vld = 0;
    repeat (n) begin
      @(negedge clk);
      vld += int'(out_valid);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset with random inputs
    rdy_mode = 1;
    load(0);
    repeat (5) begin
      @(posedge clk); #1;
      start = 1'($urandom_range(0, 1));
    end
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_last", int'(out_last), 0);
    check("rst_data", int'(out_data), 0);
    check("rst_index", int'(out_index), 0);
    n_bad_addr = 0;
    for (int b = 0; b < BANKS; b++) if (fmap_rd_addr[b] != '0) n_bad_addr++;
    check("rst_addr", n_bad_addr, 0);
    start = 1'b0;
    rst_n = 1'b1;
    idle_count(20, v_cnt);
    check("idle_valid", v_cnt, 0);

    // Full-rate sweep with the address/bank pattern
    rdy_mode = 0;
    load(1);
    @(posedge clk); #1;
    clear_counts();
    start_sweep();
    wait_done(1300);
    idle_count(5, v_cnt);
    check("full_words", words, NW);
    check("full_dones", dones, 1);

    // Backpressure, then a random ready pattern
    rdy_mode = 2;
    load(0);
    repeat (2) begin @(posedge clk); #1; end
    clear_counts();
    start_sweep();
    repeat (7) begin
      @(negedge clk);
      check("bp_hold_vld", int'(out_valid), 1);
      check("bp_hold_idx", int'(out_index), 0);
    end
    check("bp_no_words", words, 0);
    @(posedge clk); #1;
    rdy_mode = 1;
    wait_done(5000);
    idle_count(5, v_cnt);
    check("bp_words", words, NW);
    check("bp_dones", dones, 1);

    // start pulses mid-sweep and in the drain phase are ignored
    rdy_mode = 0;
    load(1);
    repeat (2) begin @(posedge clk); #1; end
    clear_counts();
    start_sweep();
    wait_k(300, 1300);
    pulse_start();
    wait_k(NW - 2, 1300);
    pulse_start();
    wait_done(100);
    idle_count(30, v_cnt);
    check("ign_tail_valid", v_cnt, 0);
    check("ign_busy", int'(busy), 0);
    check("ign_words", words, NW);
    check("ign_dones", dones, 1);

    // Reset mid-sweep
    load(0);
    clear_counts();
    start_sweep();
    wait_k(500, 1300);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    d_save = dones;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    exp_k = 0;
    words = 0;
    idle_count(5, v_cnt);
    check("mid_idle_valid", v_cnt, 0);
    check("mid_no_done", dones, d_save);
    start_sweep();
    wait_done(1300);
    idle_count(5, v_cnt);
    check("mid_words", words, NW);
    check("mid_dones", dones, 1);

    // Back-to-back sweeps, second start in the done cycle
    load(1);
    clear_counts();
    start_sweep();
    wait_done(1300);
    start_sweep();
    wait_done(1300);
    idle_count(10, v_cnt);
    check("b2b_words", words, 2 * NW);
    check("b2b_dones", dones, 2);
    check("b2b_tail_valid", v_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
